// File: rtl/count_sequence_checker.sv
// Monitor for a 4-bit free-running counter: verifies +1 mod 16 stepping,
// counts wraps while locked, and flags, counts and latches sequence errors.
module count_sequence_checker #(
  parameter int LOCK_N = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [3:0]        count_in,
  input  logic              src_clear,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic              err_sticky,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam logic [3:0]        LOCK_V   = 4'(LOCK_N);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);

  state_t     state;
  logic [3:0] prev;
  logic [3:0] match_cnt;
  logic [3:0] prev_inc;
  logic [3:0] match_next;
  logic       inc_ok;

  always_comb begin
    prev_inc   = prev + 4'd1;
    match_next = match_cnt + 4'd1;
    inc_ok     = (count_in == prev_inc);
  end

  assign state_o = state;

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= HUNT;
      prev       <= '0;
      match_cnt  <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_count <= '0;
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      prev       <= count_in;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      // A held or restarting source counter is never an error; history counters survive.
      if (src_clear) begin
        state     <= HUNT;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            state     <= SYNC;
            match_cnt <= '0;
          end
          SYNC: begin
            if (inc_ok) begin
              match_cnt <= match_next;
              if (match_next == LOCK_V) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (inc_ok) begin
              if (prev == 4'hF) begin
                wrap_pulse <= 1'b1;
                wrap_count <= wrap_count + WRAP_ONE;
              end
            end else begin
              state      <= ERROR;
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              locked     <= 1'b0;
              if (err_count != '1) err_count <= err_count + ERR_ONE;
            end
          end
          ERROR: begin
            state     <= SYNC;
            match_cnt <= '0;
          end
          default: begin
            state     <= HUNT;
            match_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Bench for count_sequence_checker: directed phases plus randomized stepping,
// compared every edge against a behavioural model of the monitoring rules.
`timescale 1ns/1ps
module tb_count_sequence_checker;
  localparam int LOCK_N = 4;
  localparam int WRAP_W = 8;
  localparam int ERR_W  = 8;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic [3:0]        count_in = '0;
  logic              src_clear = 1'b1;
  logic              locked, wrap_pulse, err_pulse, err_sticky;
  logic [WRAP_W-1:0] wrap_count;
  logic [ERR_W-1:0]  err_count;
  logic [1:0]        state_o;

  int checks = 0;
  int errors = 0;

  // reference model (phase: 0 hunt, 1 sync, 2 locked, 3 error)
  int m_phase = 0, m_prev = 0, m_run = 0;
  int m_locked = 0, m_wp = 0, m_ep = 0, m_wc = 0, m_ec = 0, m_es = 0;

  count_sequence_checker #(.LOCK_N(LOCK_N), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
    .clock(clock), .clear(clear), .count_in(count_in), .src_clear(src_clear),
    .locked(locked), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
    .err_pulse(err_pulse), .err_count(err_count), .err_sticky(err_sticky),
    .state_o(state_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int clr, input int sc, input int cin);
    int ok;
    if (clr != 0) begin
      m_phase = 0; m_prev = 0; m_run = 0; m_locked = 0;
      m_wp = 0; m_ep = 0; m_wc = 0; m_ec = 0; m_es = 0;
      return;
    end
    ok   = (cin == (m_prev + 1) % 16);
    m_wp = 0;
    m_ep = 0;
    if (sc != 0) begin
      m_phase = 0; m_run = 0; m_locked = 0;
    end else if (m_phase == 0 || m_phase == 3) begin
      m_phase = 1; m_run = 0;
    end else if (m_phase == 1) begin
      m_run = ok ? m_run + 1 : 0;
      if (m_run == LOCK_N) begin m_phase = 2; m_locked = 1; end
    end else if (ok) begin
      if (cin == 0) begin m_wp = 1; m_wc = (m_wc + 1) % (1 << WRAP_W); end
    end else begin
      m_phase = 3; m_ep = 1; m_es = 1; m_locked = 0;
      m_ec = (m_ec + 1 > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : m_ec + 1;
    end
    m_prev = cin;
  endtask

  task automatic compare_all();
    check("locked", locked, m_locked);
    check("wrap_pulse", wrap_pulse, m_wp);
    check("wrap_count", wrap_count, m_wc);
    check("err_pulse", err_pulse, m_ep);
    check("err_count", err_count, m_ec);
    check("err_sticky", err_sticky, m_es);
    check("state_o", state_o, m_phase);
  endtask

  task automatic step(input int clr, input int sc, input int cin);
    clear     = (clr != 0);
    src_clear = (sc != 0);
    count_in  = 4'(cin);
    @(posedge clock);
    model_edge(clr, sc, cin);
    #1;
    compare_all();
  endtask

  initial begin
    int v, sc, inj, budget, wraps_seen;

    // reset
    step(1, 1, 0);
    step(1, 1, 0);
    check("reset_state", state_o, 0);
    check("reset_counts", {wrap_count, err_count}, 0);

    // acquisition: locked only after LOCK_N+1 edges
    v = 0;
    for (int i = 1; i <= LOCK_N + 1; i++) begin
      step(0, 0, v);
      v = (v + 1) % 16;
      check("acq_locked", locked, (i == LOCK_N + 1) ? 1 : 0);
    end

    // three full wraps
    wraps_seen = 0;
    for (int i = 0; i < 48; i++) begin
      step(0, 0, v);
      v = (v + 1) % 16;
      if (wrap_pulse) wraps_seen++;
    end
    check("wraps_seen", wraps_seen, 3);
    check("wrap_count3", wrap_count, 3);
    check("no_err", err_count, 0);

    // forced error 5,6,9 then relock
    step(0, 0, 5);
    step(0, 0, 6);
    step(0, 0, 9);
    check("err_pulse_hi", err_pulse, 1);
    check("err_count1", err_count, 1);
    check("err_state", state_o, 3);
    step(0, 0, 10);
    check("err_pulse_lo", err_pulse, 0);
    check("resync_state", state_o, 1);
    for (int i = 11; i <= 14; i++) step(0, 0, i);
    check("relocked", locked, 1);
    check("sticky", err_sticky, 1);

    // source counter clear and release with count held at 0
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    check("srcclr_unlocked", locked, 0);
    check("srcclr_wraps_kept", wrap_count, 3);
    check("srcclr_no_err", err_count, 1);
    v = 0;
    for (int i = 1; i <= LOCK_N + 1; i++) begin
      step(0, 0, v);
      v = (v + 1) % 16;
      check("reacq_locked", locked, (i == LOCK_N + 1) ? 1 : 0);
    end

    // randomized stepping with occasional jumps and source clears
    sc = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) sc = 1 - sc;
      else if (r < 10) v = $urandom_range(0, 15);
      step(0, sc, v);
      v = (v + 1) % 16;
    end

    // 300 forced errors: count must saturate
    inj = 0;
    budget = 0;
    while (inj < 300 && budget < 20000) begin
      if (m_phase == 2) begin
        step(0, 0, (v + 5) % 16);
        inj++;
        v = (v + 6) % 16;
      end else begin
        step(0, 0, v);
        v = (v + 1) % 16;
      end
      budget++;
    end
    check("errors_injected", inj, 300);
    check("err_saturated", err_count, 255);

    // clear while locked with wrap_count 7
    step(1, 0, 0);
    v = 0;
    budget = 0;
    while ((m_wc < 7 || m_phase != 2) && budget < 1000) begin
      step(0, 0, v);
      v = (v + 1) % 16;
      budget++;
    end
    check("wc7_reached", wrap_count, 7);
    check("wc7_locked", locked, 1);
    step(1, 0, v);
    check("clr_state", state_o, 0);
    check("clr_locked", locked, 0);
    check("clr_counts", {wrap_count, err_count}, 0);
    check("clr_pulses", {wrap_pulse, err_pulse, err_sticky}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
